// File: rtl/uart_frame_tx_pkg.sv
// Shared constants for the parameter-set UART link.
// Holds the serial bit timing, the frame geometry, the byte index range
// of the parameter register file and the byte-phase type used by the
// frame transmitter. The receive path imports the same package so both
// directions agree on format and index map.
package uart_frame_tx_pkg;

  // 50 MHz clock, 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

  localparam int         FRAME_NUM_BYTES = 60;
  localparam logic [7:0] FRAME_SYNC_BYTE = 8'hA5;

  // Byte index map of the parameter register file (6-bit index, 0..59 used)
  localparam int         FRAME_IDX_W    = 6;
  localparam logic [5:0] FRAME_IDX_FIRST = 6'd0;
  localparam logic [5:0] FRAME_IDX_LAST  = 6'd59;

  // Which byte of the frame is currently on the line
  typedef enum logic [1:0] {
    PH_HDR  = 2'd0,
    PH_PAY  = 2'd1,
    PH_CSUM = 2'd2
  } frame_phase_t;

  // Running checksum: plain 8-bit sum, wraps silently
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART 8N1 serialiser.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         request to start a byte; honoured only while ready=1
//   data[7:0]    byte to send, sampled on the accepted load edge
//   tx           serial line, idle high
//   ready        high when a load on this edge is accepted: either idle,
//                or in the final clock of the stop bit so the next byte
//                follows without an idle gap
module uart_tx_byte
  import uart_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (bit_cnt == CNT_LAST);
  assign ready   = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);

  // tx is registered so the line never glitches. The shift register moves
  // one bit right per data bit, so tx always takes shreg[1] when advancing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (load && ready) begin
      state   <= ST_START;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= data;
      tx      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          tx      <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            tx      <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame-level UART transmitter returning the loaded parameter set to the host.
// On start it sends SYNC_BYTE, then NUM_BYTES payload bytes read live
// through rd_idx/rd_data in index order, then an 8-bit payload checksum.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        one-cycle frame request, dropped while busy or done
//   rd_idx[5:0]  byte index into the register-file read mux
//   rd_data[7:0] combinational byte at rd_idx
//   tx           serial line, idle high
//   busy         high while a frame is in flight
//   done         one-cycle pulse on the cycle busy falls
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int         NUM_BYTES    = FRAME_NUM_BYTES,
  parameter logic [7:0] SYNC_BYTE    = FRAME_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] rd_idx,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_BYTES - 1);

  frame_phase_t phase;
  logic [7:0]   checksum;
  logic         pay_last;
  logic         accept;
  logic         byte_end;
  logic         byte_load;
  logic [7:0]   byte_data;
  logic         tx_ready;
  logic         next_is_pay;

  // While busy the serialiser is never idle, so its ready flag marks the
  // last clock of each stop bit: the edge where the next byte must load.
  assign accept      = start && !busy && !done;
  assign byte_end    = busy && tx_ready;
  assign next_is_pay = (phase == PH_HDR) || ((phase == PH_PAY) && !pay_last);

  always_comb begin
    byte_load = 1'b0;
    byte_data = SYNC_BYTE;
    if (accept) begin
      byte_load = 1'b1;
      byte_data = SYNC_BYTE;
    end else if (byte_end && (phase != PH_CSUM)) begin
      byte_load = 1'b1;
      byte_data = next_is_pay ? rd_data : checksum;
    end
  end

  // Frame sequencing. rd_idx saturates at the last index; pay_last then
  // remembers that the final payload byte is on the line so the next
  // byte boundary hands over to the checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_idx   <= '0;
      checksum <= '0;
      phase    <= PH_HDR;
      pay_last <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        phase    <= PH_HDR;
        checksum <= '0;
        rd_idx   <= '0;
        pay_last <= 1'b0;
      end else if (byte_end) begin
        if (phase == PH_CSUM) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          rd_idx <= '0;
          phase  <= PH_HDR;
        end else if (next_is_pay) begin
          phase    <= PH_PAY;
          checksum <= csum_add(checksum, rd_data);
          if (rd_idx == LAST_IDX) begin
            pay_last <= 1'b1;
          end else begin
            rd_idx <= rd_idx + 6'd1;
          end
        end else begin
          phase <= PH_CSUM;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk   (clk),
    .reset (reset),
    .load  (byte_load),
    .data  (byte_data),
    .tx    (tx),
    .ready (tx_ready)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx with 4 clocks per bit.
// Models the parameter register file behind rd_idx/rd_data and a UART
// receiver sampling each bit in its middle.
module tb_uart_frame_tx;

  localparam int CPB   = 4;
  localparam int NB    = 60;
  localparam int FLEN  = (NB + 2) * 10 * CPB;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] rdIdx;
  logic [7:0] rdData;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] regs   [NB];
  logic [7:0] expPay [NB];

  int total;
  int bad;
  int cyc;
  int accCyc;
  int doneCyc;
  int frameTimeout;
  int idxOver;

  logic [7:0] rxBytes [$];
  int         rxStart [$];
  int         framingErr;
  int         monT0;
  logic [7:0] monByte;

  uart_frame_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rd_idx  (rdIdx),
    .rd_data (rdData),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  // Register file read mux model
  assign rdData = (rdIdx < 6'd60) ? regs[rdIdx] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdIdx > 6'd59) idxOver++;
  end

  // UART receiver: detects the start bit's first low cycle and samples mid-bit
  always begin
    @(negedge clk);
    if (tx === 1'b0) begin
      monT0 = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge clk);
        monByte[b] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) framingErr++;
      rxBytes.push_back(monByte);
      rxStart.push_back(monT0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clearRx();
    rxBytes.delete();
    rxStart.delete();
    framingErr = 0;
  endtask

  // Pulse start, then wait (bounded) for the done pulse
  task automatic applyStimulus();
    frameTimeout = 0;
    doneCyc      = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    accCyc = cyc;
    for (int i = 0; i < FLEN + 500 && doneCyc == 0; i++) begin
      @(negedge clk);
      if (done) doneCyc = cyc;
    end
    if (doneCyc == 0) frameTimeout = 1;
  endtask

  // Compare the decoded frame against SYNC, expPay and their checksum
  task automatic checkFrame(input string tag);
    logic [7:0] sum;
    int         gapErr;
    checkOutput({tag, "_rx_count"}, rxBytes.size(), NB + 2);
    checkOutput({tag, "_stop_bits"}, framingErr, 0);
    if (rxBytes.size() == NB + 2) begin
      checkOutput({tag, "_sync"}, rxBytes[0], 8'hA5);
      sum = 8'h00;
      for (int i = 0; i < NB; i++) begin
        sum = sum + expPay[i];
        checkOutput($sformatf("%s_pay%0d", tag, i), rxBytes[i + 1], expPay[i]);
      end
      checkOutput({tag, "_csum"}, rxBytes[NB + 1], sum);
      gapErr = 0;
      for (int j = 1; j < NB + 2; j++) begin
        if (rxStart[j] - rxStart[j - 1] != 10 * CPB) gapErr++;
      end
      checkOutput({tag, "_byte_gap"}, gapErr, 0);
      checkOutput({tag, "_first_start"}, rxStart[0], accCyc);
    end
  endtask

  initial begin
    int viol;
    int doneCount;
    int busyGap;
    int busyAfter;
    int found;
    total      = 0;
    bad        = 0;
    idxOver    = 0;
    framingErr = 0;
    reset      = 1'b1;
    start      = 1'b0;
    for (int i = 0; i < NB; i++) regs[i] = 8'(i + 1);

    // Test 1: reset state and idle line
    repeat (3) @(negedge clk);
    checkOutput("t1_rst_tx", tx, 1'b1);
    checkOutput("t1_rst_busy", busy, 1'b0);
    checkOutput("t1_rst_done", done, 1'b0);
    checkOutput("t1_rst_idx", rdIdx, 6'd0);
    reset = 1'b0;
    viol  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rdIdx !== 6'd0) viol++;
    end
    checkOutput("t1_idle", viol, 0);

    // Test 2: payload idx+1
    for (int i = 0; i < NB; i++) begin
      regs[i]   = 8'(i + 1);
      expPay[i] = 8'(i + 1);
    end
    clearRx();
    applyStimulus();
    checkOutput("t2_timeout", frameTimeout, 0);
    checkOutput("t2_len", doneCyc - accCyc, FLEN);
    checkFrame("t2");
    @(negedge clk);
    checkOutput("t2_done_pulse", done, 1'b0);
    checkOutput("t2_busy_after", busy, 1'b0);
    checkOutput("t2_idx_after", rdIdx, 6'd0);

    // Test 3: all 0xFF payload, checksum wraps to 0xC4
    for (int i = 0; i < NB; i++) begin
      regs[i]   = 8'hFF;
      expPay[i] = 8'hFF;
    end
    repeat (5) @(negedge clk);
    clearRx();
    applyStimulus();
    checkOutput("t3_timeout", frameTimeout, 0);
    checkFrame("t3");
    if (rxBytes.size() == NB + 2) checkOutput("t3_csum_c4", rxBytes[NB + 1], 8'hC4);

    // Test 4: start re-pulsed mid-frame and on the done cycle
    for (int i = 0; i < NB; i++) begin
      regs[i]   = 8'(i * 3);
      expPay[i] = 8'(i * 3);
    end
    repeat (5) @(negedge clk);
    clearRx();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    accCyc    = cyc;
    doneCount = 0;
    doneCyc   = 0;
    busyGap   = 0;
    busyAfter = 0;
    for (int i = 1; i <= FLEN + 120; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        doneCount++;
        doneCyc = cyc;
        start   = 1'b1;
      end else if (cyc - accCyc == 10 || cyc - accCyc == 1000) begin
        start = 1'b1;
      end
      if (doneCount == 0 && !done && !busy) busyGap++;
      if (doneCount > 0 && busy) busyAfter++;
    end
    start = 1'b0;
    checkOutput("t4_done_count", doneCount, 1);
    checkOutput("t4_len", doneCyc - accCyc, FLEN);
    checkOutput("t4_busy_gap", busyGap, 0);
    checkOutput("t4_busy_after", busyAfter, 0);
    checkFrame("t4");

    // Test 5: reset mid-payload at rd_idx=20, then a clean frame
    for (int i = 0; i < NB; i++) begin
      regs[i]   = 8'(255 - i);
      expPay[i] = 8'(255 - i);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < FLEN && found == 0; i++) begin
      @(negedge clk);
      if (rdIdx == 6'd20) found = 1;
    end
    checkOutput("t5_reach_idx20", found, 1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_tx", tx, 1'b1);
    checkOutput("t5_rst_busy", busy, 1'b0);
    checkOutput("t5_rst_idx", rdIdx, 6'd0);
    reset = 1'b0;
    start = 1'b0;
    viol  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done || busy || tx !== 1'b1) viol++;
    end
    checkOutput("t5_no_done", viol, 0);
    clearRx();
    applyStimulus();
    checkOutput("t5_timeout", frameTimeout, 0);
    checkOutput("t5_len", doneCyc - accCyc, FLEN);
    checkFrame("t5");

    // Test 6: live read - byte 30 changed before its load, byte 5 after
    for (int i = 0; i < NB; i++) begin
      regs[i]   = 8'(i + 16);
      expPay[i] = 8'(i + 16);
    end
    expPay[30] = 8'hC3;
    repeat (5) @(negedge clk);
    clearRx();
    fork
      applyStimulus();
      begin
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
        repeat (300) @(negedge clk);
        regs[5] = 8'h77;
        repeat (300) @(negedge clk);
        regs[30] = 8'hC3;
      end
    join
    checkOutput("t6_timeout", frameTimeout, 0);
    checkFrame("t6");

    checkOutput("idx_range", idxOver, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
